// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
package mult_share_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREQ_DEF  = 4;
    // Widest requester id the stage records carry (NREQ up to 8).
    localparam int ID_MAXW   = 3;

    // Issue-stage record: who asked, and the operand pair.
    typedef struct packed {
        logic [ID_MAXW-1:0]   id;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
    } mult_req_t;

    // Result-stage record: who asked, the full product and the overflow flag.
    typedef struct packed {
        logic [ID_MAXW-1:0]     id;
        logic [2*WIDTH_DEF-1:0] prod;
        logic                   ovf;
    } mult_rsp_t;

    // True when the product does not fit in WIDTH_DEF bits.
    function automatic logic upper_nonzero(input logic [2*WIDTH_DEF-1:0] p);
        return |p[2*WIDTH_DEF-1:WIDTH_DEF];
    endfunction

endpackage

// File: rtl/if_multiplier.sv
// Operand/product bundle between the controller and the shared multiplier.
interface if_multiplier #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;

    modport src (output a, output b, input  p);
    modport mul (input  a, input  b, output p);
endinterface

// File: rtl/dadda_16.sv
// 16x16 unsigned combinational multiplier. The partial-product array is
// built explicitly; the column reduction is left to the adder mapping.
module dadda_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [31:0] pp [16];

    // One shifted, gated copy of b per bit of a.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pp
            assign pp[gi] = {16'b0, b & {16{a[gi]}}} << gi;
        end
    endgenerate

    // Sum all partial products into the full-width product.
    always_comb begin
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p = p + pp[i];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rr_ptr marks the highest-priority requester and
// moves to one past the winner on every grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] rr_ptr_next;
    logic           found;

    // Scan from the pointer, wrapping modulo NREQ, for the first valid request.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!found && valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // One-hot grant, suppressed entirely when not enabled.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = en && found && (grant_idx == IDW'(gi));
        end
    endgenerate

    assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Advance the pointer past the winner; hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (en && found) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational multiplier among NREQ requesters through a
// two-stage pipeline (issue, result) with a tagged, back-pressured response.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_prod,
    output logic                  rsp_ovf,
    output logic                  busy
);
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    logic             stall;
    logic             arb_en;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;

    mult_req_t        s1_reg;
    mult_req_t        s1_next;
    logic             s1_valid_reg;
    mult_rsp_t        s2_reg;
    mult_rsp_t        s2_next;
    logic             s2_valid_reg;
    logic             unused_id_bits;

    // Unpack the flattened operand buses per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A held result freezes the whole pipe; reset also blocks grants so
    // req_ready reads zero while rst is high.
    assign stall  = s2_valid_reg && !rsp_ready;
    assign arb_en = !stall && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    if_multiplier #(.WIDTH(WIDTH)) mul_if ();

    assign mul_if.a = s1_reg.a;
    assign mul_if.b = s1_reg.b;

    dadda_16 u_mul (
        .a (mul_if.a),
        .b (mul_if.b),
        .p (mul_if.p)
    );

    // Build the next issue record from the granted requester and the next
    // result record from the multiplier output.
    always_comb begin
        s1_next.id   = ID_MAXW'(grant_idx);
        s1_next.a    = a_arr[grant_idx];
        s1_next.b    = b_arr[grant_idx];
        s2_next.id   = s1_reg.id;
        s2_next.prod = mul_if.p;
        s2_next.ovf  = upper_nonzero(mul_if.p);
    end

    // Advance both stages together unless the result is being held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
            s2_valid_reg <= 1'b0;
            s2_reg       <= '0;
        end else if (!stall) begin
            s2_valid_reg <= s1_valid_reg;
            s2_reg       <= s2_next;
            s1_valid_reg <= |grant;
            if (|grant) begin
                s1_reg <= s1_next;
            end
        end
    end

    assign req_ready      = grant;
    assign rsp_valid      = s2_valid_reg;
    assign rsp_id         = s2_reg.id[IDW-1:0];
    assign rsp_prod       = s2_reg.prod;
    assign rsp_ovf        = s2_reg.ovf;
    assign busy           = s1_valid_reg || s2_valid_reg;
    assign unused_id_bits = ^s2_reg.id;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: a queue-based reference model
// checked every cycle, plus directed cases with literal expectations.
module tb_mult_share_ctrl;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  rsp_ovf;
    logic                  busy;

    mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt    = 0;
    int pass_cnt   = 0;
    int resp_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each in-flight entry records how many unstalled edges it has seen;
    // it is presented as the response once it has seen two.
    typedef struct {
        int          id;
        logic [31:0] prod;
        int          s;
    } ent_t;

    ent_t mq[$];
    int   mptr = 0;

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] mul32(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ax;
        logic [31:0] bx;
        ax = {16'b0, a};
        bx = {16'b0, b};
        return ax * bx;
    endfunction

    initial begin
        bit   m_vis;
        bit   m_st;
        int   m_w;
        ent_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mptr = 0;
            end else begin
                m_vis = (mq.size() > 0) && (mq[0].s >= 2);
                m_st  = m_vis && !rsp_ready;
                if (!m_st) begin
                    if (m_vis) void'(mq.pop_front());
                    foreach (mq[k]) mq[k].s++;
                    m_w = winner(req_valid, mptr);
                    if (m_w >= 0) begin
                        e.id   = m_w;
                        e.prod = mul32(req_a[m_w*WIDTH +: WIDTH], req_b[m_w*WIDTH +: WIDTH]);
                        e.s    = 1;
                        mq.push_back(e);
                        mptr = (m_w + 1) % NREQ;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit              c_vis;
        bit              c_st;
        int              c_w;
        logic [NREQ-1:0] c_eg;
        logic [31:0]     c_prod;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", 64'(req_ready), 64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_rsp_prod", 64'(rsp_prod), 64'(0));
                chk("rst_rsp_id", 64'(rsp_id), 64'(0));
                chk("rst_rsp_ovf", 64'(rsp_ovf), 64'(0));
            end else begin
                c_vis = (mq.size() > 0) && (mq[0].s >= 2);
                c_st  = c_vis && !rsp_ready;
                c_w   = c_st ? -1 : winner(req_valid, mptr);
                c_eg  = (c_w >= 0) ? NREQ'(1 << c_w) : '0;
                chk("grant", 64'(req_ready), 64'(c_eg));
                chk("rsp_valid", 64'(rsp_valid), 64'(c_vis));
                chk("busy", 64'(busy), 64'(mq.size() > 0));
                if (c_vis) begin
                    c_prod = mq[0].prod;
                    chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
                    chk("rsp_prod", 64'(rsp_prod), 64'(c_prod));
                    chk("rsp_ovf", 64'(rsp_ovf), 64'(c_prod[31:16] != 16'h0));
                    if (rsp_ready) resp_count++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [NREQ-1:0] gseen;

    // One clock: requesters that were granted drop their valid afterwards.
    task automatic cyc();
        @(negedge clk);
        gseen = req_ready & req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~gseen;
    endtask

    task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b);
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return 16'hffff;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while ((mq.size() != 0 || req_valid != 0) && n < 60) begin
            cyc();
            n++;
        end
        chk("drain_done", 64'(mq.size() == 0 && req_valid == 0), 64'(1));
    endtask

    // Single isolated request with literal latency and result expectations.
    task automatic single(input int r, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] eprod, input logic eovf);
        rsp_ready = 1'b1;
        set_op(r, a, b);
        req_valid[r] = 1'b1;
        #1;
        chk("single_grant", 64'(req_ready), 64'(1 << r));
        cyc();
        chk("single_t1_valid", 64'(rsp_valid), 64'(0));
        cyc();
        chk("single_t2_valid", 64'(rsp_valid), 64'(1));
        chk("single_id", 64'(rsp_id), 64'(r));
        chk("single_prod", 64'(rsp_prod), 64'(eprod));
        chk("single_ovf", 64'(rsp_ovf), 64'(eovf));
        cyc();
        chk("single_idle", 64'(busy), 64'(0));
    endtask

    int fair_exp [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int gidx;
        int start;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        do_reset();

        // Idle after reset.
        cyc();
        chk("idle_ready", 64'(req_ready), 64'(0));
        chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // Single request and boundary operands.
        single(2, 16'h0fff, 16'h0fff, 32'h00ffe001, 1'b1);
        single(1, 16'hffff, 16'hffff, 32'hfffe0001, 1'b1);
        single(3, 16'h00ff, 16'h0001, 32'h000000ff, 1'b0);
        single(0, 16'h0000, 16'h1234, 32'h00000000, 1'b0);

        // Fairness: everyone valid all the time.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
        req_valid = '1;
        for (int n = 0; n < 6; n++) begin
            #1;
            gidx = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
            chk("fair_grant", 64'(gidx), 64'(fair_exp[n]));
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    set_op(i, rand_op(), rand_op());
                    req_valid[i] = 1'b1;
                end
            end
        end
        req_valid = '0;
        drain();

        // Backpressure: three requests, consumer stalls for five cycles.
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_op(i, rand_op(), rand_op());
        req_valid = 4'b0111;
        for (int n = 0; n < 5; n++) begin
            if (n >= 2) begin
                chk("bp_no_grant", 64'(req_ready), 64'(0));
                chk("bp_hold_id", 64'(rsp_id), 64'(0));
            end
            cyc();
        end
        start = resp_count;
        drain();
        chk("bp_count", 64'(resp_count - start), 64'(3));

        // Reset with two entries in flight.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
        req_valid = '1;
        cyc();
        cyc();
        chk("mid_two_in_flight", 64'(busy), 64'(1));
        req_valid = '0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        cyc();
        cyc();
        rst       = 1'b0;
        req_valid = '1;
        #1;
        chk("mid_ptr_zero", 64'(req_ready), 64'(1));
        cyc();
        req_valid = '0;
        drain();
        single(1, 16'h1234, 16'h0010, 32'h00012340, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_op(i, rand_op(), rand_op());
                    req_valid[i] = 1'b1;
                end
            end
            cyc();
        end
        req_valid = '0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
